// File: rtl/btn_step_debounce_if.sv
// Button-side bundle for btn_step_debounce: raw input plus debounced status and step pulse.
// The master drives the raw button; the slave is the debouncer.
interface btn_step_debounce_if;
  logic       btn_raw;
  logic       btn_level;
  logic       step_pulse;
  logic [7:0] press_cnt;

  modport master (output btn_raw, input btn_level, input step_pulse, input press_cnt);
  modport slave  (input btn_raw, output btn_level, output step_pulse, output press_cnt);
endinterface

// File: rtl/btn_step_debounce.sv
// Push-button debouncer: two-flop synchronizer, four-state accept/release FSM, one-cycle step
// pulse per press with optional auto-repeat, debounced level and a wrapping press counter.
module btn_step_debounce #(
  parameter int unsigned STABLE_CYCLES = 1000000,
  parameter int unsigned CNT_W         = 20,
  parameter int unsigned REPEAT_DELAY  = 0,
  parameter int unsigned REPEAT_RATE   = 250000
) (
  input  logic               clk,
  input  logic               RESET,
  btn_step_debounce_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ARM_PRESS, HELD, ARM_RELEASE} state_e;

  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LAST   = CNT_W'(REPEAT_RATE - 1);
  localparam bit               REPEAT_EN   = (REPEAT_DELAY != 0);

  logic             sync1_q, sync2_q;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             rep_phase_q, rep_phase_d;
  logic             level_q, level_d;
  logic             pulse_q, pulse_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             btn_sync;
  logic [CNT_W-1:0] repeat_last;

  assign btn_sync = sync2_q;

  // NOTE: all state updates use non-blocking assignments, and reset is sampled on the clock edge
  // so that every flop, synchronizer included, clears on the same edge with no async path.
  always_ff @(posedge clk) begin
    if (RESET) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      state_q     <= IDLE;
      timer_q     <= '0;
      rep_phase_q <= 1'b0;
      level_q     <= 1'b0;
      pulse_q     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      sync1_q     <= bus.btn_raw;
      sync2_q     <= sync1_q;
      state_q     <= state_d;
      timer_q     <= timer_d;
      rep_phase_q <= rep_phase_d;
      level_q     <= level_d;
      pulse_q     <= pulse_d;
      cnt_q       <= cnt_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    rep_phase_d = rep_phase_q;
    level_d     = level_q;
    pulse_d     = 1'b0;
    cnt_d       = cnt_q;
    // First repeat waits REPEAT_DELAY cycles, later ones REPEAT_RATE.
    repeat_last = rep_phase_q ? RATE_LAST : DELAY_LAST;

    unique case (state_q)
      IDLE: begin
        level_d = 1'b0;
        timer_d = '0;
        if (btn_sync) state_d = ARM_PRESS;
      end
      ARM_PRESS: begin
        if (!btn_sync) begin
          state_d = IDLE;
          timer_d = '0;
        end else if (timer_q == STABLE_LAST) begin
          state_d     = HELD;
          timer_d     = '0;
          rep_phase_d = 1'b0;
          level_d     = 1'b1;
          pulse_d     = 1'b1;
          cnt_d       = cnt_q + 8'd1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      HELD: begin
        level_d = 1'b1;
        if (!btn_sync) begin
          state_d = ARM_RELEASE;
          timer_d = '0;
        end else if (REPEAT_EN) begin
          if (timer_q == repeat_last) begin
            pulse_d     = 1'b1;
            timer_d     = '0;
            rep_phase_d = 1'b1;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
      end
      ARM_RELEASE: begin
        level_d = 1'b1;
        if (btn_sync) begin
          state_d     = HELD;
          timer_d     = '0;
          rep_phase_d = 1'b0;
        end else if (timer_q == STABLE_LAST) begin
          state_d = IDLE;
          timer_d = '0;
          level_d = 1'b0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
  end

  assign bus.btn_level  = level_q;
  assign bus.step_pulse = pulse_q;
  assign bus.press_cnt  = cnt_q;

  // A repeat delay or rate below 2 would let two pulses land on adjacent cycles.
  param_ok: assert property (@(posedge clk)
    STABLE_CYCLES >= 2 && (REPEAT_DELAY == 0 || (REPEAT_DELAY >= 2 && REPEAT_RATE >= 2)));
  single_pulse: assert property (@(posedge clk) disable iff (RESET) pulse_q |=> !pulse_q);

endmodule
